// File: rtl/hcg_lpi_responder_if.sv
// hcg_lpi_responder_if: low-power C-channel bundle between
// the clock-gating controller / peripheral and the responder.
interface hcg_lpi_responder_if #(
  parameter int OUTSTD_W = 4
);
  logic                CSYSREQ_i;
  logic                txn_start_i;
  logic                txn_done_i;
  logic                wake_i;
  logic                CSYSACK_o;
  logic                CACTIVE_o;
  logic                txn_allow_o;
  logic [OUTSTD_W-1:0] outstd_cnt_o;
  logic                err_o;

  modport master (
    output CSYSREQ_i,
    output txn_start_i,
    output txn_done_i,
    output wake_i,
    input  CSYSACK_o,
    input  CACTIVE_o,
    input  txn_allow_o,
    input  outstd_cnt_o,
    input  err_o
  );

  modport slave (
    input  CSYSREQ_i,
    input  txn_start_i,
    input  txn_done_i,
    input  wake_i,
    output CSYSACK_o,
    output CACTIVE_o,
    output txn_allow_o,
    output outstd_cnt_o,
    output err_o
  );
endinterface

// File: rtl/hcg_lpi_responder.sv
// hcg_lpi_responder: peripheral-side LPI responder with idle
// hysteresis. Optional denial state: define HCG_LPI_DENY_EN.
module hcg_lpi_responder #(
  parameter int OUTSTD_W    = 4,
  parameter int IDLE_CYCLES = 16
) (
  input logic               clk_i,
  input logic               rstn_i,
  hcg_lpi_responder_if.slave lpi
);

  localparam int IW =
    (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LD = IW'(IDLE_CYCLES);
  localparam logic [OUTSTD_W-1:0] CNT_MAX = '1;

`ifdef HCG_LPI_DENY_EN
  typedef enum logic [1:0] {
    LOWPWR = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    DENY   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    LOWPWR = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_e;
`endif

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                req_s_q, req_s_d;
  logic                ack_q, ack_d;
  logic                active_q, active_d;
  logic                allow_q, allow_d;
  logic [OUTSTD_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [IW-1:0]       idle_q, idle_d;

  logic start_ok;
  logic start_bad;
  logic activity;

  // Outstanding count, error flag and idle hysteresis.
  always_comb begin
    start_ok  = lpi.txn_start_i & allow_q;
    start_bad = lpi.txn_start_i & ~allow_q;
    cnt_d     = cnt_q;
    err_d     = err_q | start_bad;
    if (start_ok && !lpi.txn_done_i) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (lpi.txn_done_i && !start_ok) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
    activity = (cnt_q != '0) | lpi.txn_start_i
             | lpi.wake_i;
    if (activity)          idle_d = IDLE_LD;
    else if (idle_q != '0) idle_d = idle_q - 1'b1;
    else                   idle_d = idle_q;
  end

  // Handshake state machine and registered outputs.
  always_comb begin
    sync1_d = lpi.CSYSREQ_i;
    req_s_d = sync1_q;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!req_s_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (req_s_q)
          state_d = RUN;
`ifdef HCG_LPI_DENY_EN
        else if (lpi.wake_i)
          state_d = DENY;
`endif
        else if (cnt_q == '0 && !active_q)
          state_d = LOWPWR;
      end
`ifdef HCG_LPI_DENY_EN
      DENY: begin
        if (req_s_q) state_d = RUN;
      end
`endif
      LOWPWR: begin
        if (req_s_q) state_d = RUN;
      end
      default: state_d = LOWPWR;
    endcase
    active_d = activity | (idle_q != '0);
`ifdef HCG_LPI_DENY_EN
    if (state_d == DENY) active_d = 1'b1;
`endif
    ack_d   = (state_d == RUN) | (state_d == DRAIN);
    allow_d = (state_d == RUN);
  end

  // All state and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= LOWPWR;
      sync1_q  <= 1'b0;
      req_s_q  <= 1'b0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
      allow_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      req_s_q  <= req_s_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      allow_q  <= allow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
    end
  end

  assign lpi.CSYSACK_o    = ack_q;
  assign lpi.CACTIVE_o    = active_q;
  assign lpi.txn_allow_o  = allow_q;
  assign lpi.outstd_cnt_o = cnt_q;
  assign lpi.err_o        = err_q;

endmodule

// File: tb/tb_hcg_lpi_responder.sv
// tb_hcg_lpi_responder: directed scoreboard bench for the
// LPI responder (OUTSTD_W=4, IDLE_CYCLES=16).
module tb_hcg_lpi_responder;

  localparam int SACK = 0;
  localparam int SACT = 1;
  localparam int SALW = 2;
  localparam int SCNT = 3;
  localparam int SERR = 4;

  logic clk = 1'b0;
  logic rstn;

  hcg_lpi_responder_if #(.OUTSTD_W(4)) bus ();

  hcg_lpi_responder #(
    .OUTSTD_W(4),
    .IDLE_CYCLES(16)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .lpi   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input int s,
                      input int e);
    exp_t x;
    x.tag = t;
    x.sel = s;
    x.exp = 32'(e);
    sb.push_back(x);
  endtask

  task automatic push5(input string t, input int ack,
                       input int act, input int alw,
                       input int cnt, input int err);
    push({t, ".ack"}, SACK, ack);
    push({t, ".act"}, SACT, act);
    push({t, ".alw"}, SALW, alw);
    push({t, ".cnt"}, SCNT, cnt);
    push({t, ".err"}, SERR, err);
  endtask

  function automatic logic [31:0] obs(input int s);
    case (s)
      SACK:    return {31'b0, bus.CSYSACK_o};
      SACT:    return {31'b0, bus.CACTIVE_o};
      SALW:    return {31'b0, bus.txn_allow_o};
      SCNT:    return 32'(bus.outstd_cnt_o);
      default: return {31'b0, bus.err_o};
    endcase
  endfunction

  task automatic check();
    exp_t        x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sel);
      n_cmp++;
      assert (o === x.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h",
               x.tag, o, x.exp);
      end
    end
  endtask

  initial begin
    rstn            = 1'b0;
    bus.CSYSREQ_i   = 1'b0;
    bus.txn_start_i = 1'b0;
    bus.txn_done_i  = 1'b0;
    bus.wake_i      = 1'b0;
    tick(2);
    push5("reset", 0, 0, 0, 0, 0);
    check();
    rstn = 1'b1;

    // wake raises CACTIVE one cycle later
    bus.wake_i = 1'b1;
    tick(1);
    push("wake_act", SACT, 1);
    check();

    // request: ack/allow three cycles after the pin
    bus.CSYSREQ_i = 1'b1;
    tick(2);
    push("req+2.ack", SACK, 0);
    push("req+2.alw", SALW, 0);
    check();
    tick(1);
    push("req+3.ack", SACK, 1);
    push("req+3.alw", SALW, 1);
    check();

    // three starts then three dones
    bus.wake_i      = 1'b0;
    bus.txn_start_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      push("cnt_up", SCNT, i);
      check();
    end
    bus.txn_start_i = 1'b0;
    bus.txn_done_i  = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick(1);
      push("cnt_dn", SCNT, i);
      check();
    end
    bus.txn_done_i = 1'b0;
    tick(16);
    push("idle_hold", SACT, 1);
    check();
    tick(1);
    push("idle_fall", SACT, 0);
    check();

    // drain with two outstanding
    bus.txn_start_i = 1'b1;
    tick(2);
    bus.txn_start_i = 1'b0;
    push("drn_pre.cnt", SCNT, 2);
    check();
    bus.CSYSREQ_i = 1'b0;
    tick(2);
    push("drn+2.alw", SALW, 1);
    push("drn+2.ack", SACK, 1);
    check();
    tick(1);
    push("drn+3.alw", SALW, 0);
    push("drn+3.ack", SACK, 1);
    check();
    bus.txn_start_i = 1'b1;
    tick(1);
    bus.txn_start_i = 1'b0;
    push("bad_start.cnt", SCNT, 2);
    push("bad_start.err", SERR, 1);
    check();
    bus.txn_done_i = 1'b1;
    tick(2);
    bus.txn_done_i = 1'b0;
    push("drn_empty.cnt", SCNT, 0);
    push("drn_empty.ack", SACK, 1);
    check();
    tick(16);
    push("drn_hold.act", SACT, 1);
    push("drn_hold.ack", SACK, 1);
    check();
    tick(1);
    push("drn_idle.act", SACT, 0);
    push("drn_idle.ack", SACK, 1);
    check();
    tick(1);
    push("lowpwr.ack", SACK, 0);
    push("lowpwr.alw", SALW, 0);
    check();

    // reset asserted mid-handshake
    bus.CSYSREQ_i = 1'b1;
    tick(3);
    push("rerun.ack", SACK, 1);
    check();
    rstn = 1'b0;
    #1;
    push5("mid_reset", 0, 0, 0, 0, 0);
    check();
    rstn = 1'b1;
    tick(2);
    push("rel+2.ack", SACK, 0);
    check();
    tick(1);
    push("rel+3.ack", SACK, 1);
    push("rel+3.alw", SALW, 1);
    check();

    // saturation
    bus.txn_start_i = 1'b1;
    tick(15);
    push("sat15.cnt", SCNT, 15);
    push("sat15.err", SERR, 0);
    check();
    tick(1);
    push("sat16.cnt", SCNT, 15);
    push("sat16.err", SERR, 1);
    check();
    bus.txn_start_i = 1'b0;
    bus.txn_done_i  = 1'b1;
    tick(10);
    push("to5.cnt", SCNT, 5);
    check();
    bus.txn_start_i = 1'b1;
    tick(1);
    bus.txn_start_i = 1'b0;
    bus.txn_done_i  = 1'b0;
    push("both.cnt", SCNT, 5);
    check();

    // abort a drain
    bus.CSYSREQ_i = 1'b0;
    tick(2);
    push("ab+2.alw", SALW, 1);
    check();
    tick(1);
    push("ab+3.alw", SALW, 0);
    push("ab+3.ack", SACK, 1);
    check();
    bus.CSYSREQ_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      push("abr.ack", SACK, 1);
      push("abr.alw", SALW, 0);
      check();
    end
    tick(1);
    push("abr+3.ack", SACK, 1);
    push("abr+3.alw", SALW, 1);
    push("abr+3.cnt", SCNT, 5);
    check();
    bus.txn_done_i = 1'b1;
    tick(5);
    bus.txn_done_i = 1'b0;
    push("empty.cnt", SCNT, 0);
    check();

    // wake during drain
    bus.CSYSREQ_i = 1'b0;
    tick(3);
    push("dw+3.ack", SACK, 1);
    push("dw+3.alw", SALW, 0);
    check();
    bus.wake_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
`ifdef HCG_LPI_DENY_EN
      push("deny.ack", SACK, 0);
`else
      push("dwait.ack", SACK, 1);
`endif
      push("dw.act", SACT, 1);
      push("dw.alw", SALW, 0);
      check();
    end
    bus.CSYSREQ_i = 1'b1;
    tick(3);
    push("dw_run.ack", SACK, 1);
    push("dw_run.alw", SALW, 1);
    push("dw_run.act", SACT, 1);
    check();
    bus.wake_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
